mem_responder: RTL
==================

# mem_responder

Single-port memory responder for the req/gnt/rvalid memory protocol used between cores, the RAM port mux and on-chip RAM. It accepts one transaction at a time on its slave port and performs byte-enabled writes or word reads on an internal storage array. It returns a one-cycle rvalid response after a configurable latency, and can insert grant wait-states. It stands in for the RAM behind the port mux and serves as the programmable-latency memory model for core verification.

## Interface
- ADDR_WIDTH, 32, request address width (byte address)
- DATA_WIDTH, 32, word width; multiple of 8
- DEPTH, 1024, number of words; power of two
- LATENCY, 1, cycles from grant edge to rvalid; ≥1
- GNT_STALL, 0, cycles a request is held before grant; ≥0

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_i  in  1  request
- gnt_o  out  1  grant; combinational
- addr_i  in  ADDR_WIDTH  byte address
- we_i  in  1  1=write, 0=read
- be_i  in  DATA_WIDTH/8  byte enables
- wdata_i  in  DATA_WIDTH  write data
- rvalid_o  out  1  response valid, one-cycle pulse per grant
- rdata_o  out  DATA_WIDTH  response data

## Operation
- Word index = addr_i[$clog2(DATA_WIDTH/8) +: $clog2(DEPTH)]. Lower byte-offset bits are ignored. Upper bits are ignored, so addresses alias modulo DEPTH words.
- FSM states:
  - IDLE: no transaction pending.
  - WAIT: latency countdown.
  - RESP: rvalid_o=1.
- Accept window: state IDLE or RESP.
- Stall counter: increments, saturating at GNT_STALL, on every cycle with req_i=1 and gnt_o=0, in any state. It clears when req_i=0 or on a grant.
- gnt_o = req_i & ~rst & (state ∈ {IDLE, RESP}) & (stall_cnt == GNT_STALL).
- On a grant edge:
  - Write: memory updated only in bytes where be_i=1. Latched rdata = 0.
  - Read: latched rdata = stored word (pre-existing contents).
  - Next state is RESP if LATENCY=1; otherwise WAIT with lat_cnt = LATENCY-1.
- WAIT: lat_cnt decrements each cycle. When lat_cnt reaches 1, the next state is RESP.
- RESP: rvalid_o=1 and rdata_o = latched data.
  - A grant in this cycle starts the next transaction as from IDLE.
  - Otherwise the next state is IDLE.
- rdata_o holds its last response value until the next response. It is not cleared after rvalid.
- Address, we, be and wdata are sampled only at the grant edge. Changes while req_i is waiting are legal and take the last value.
- Memory contents are not reset and power up undefined in synthesis. The bench initialises any location it reads.

## Timing
- Reset values: state IDLE, rvalid_o=0, rdata_o=0, stall and latency counters 0. gnt_o=0 while rst=1.
- Grant at cycle N (req_i=1 for GNT_STALL+1 consecutive cycles, in the accept window) gives rvalid_o=1 in cycle N+LATENCY.
- LATENCY=1, GNT_STALL=0: a request held continuously is granted every cycle, with rvalid one cycle behind each grant (full throughput).
- LATENCY>1: at most one outstanding transaction. req_i is not granted during WAIT.
- A write is committed at the grant edge. A read granted in the following cycle returns the new data.
- Reset asserted in WAIT or RESP:
  - The pending response is dropped; rvalid_o=0 from the next cycle and rdata_o=0.
  - A write already granted stays committed.
- req_i deasserted before grant is legal. No transaction occurs and the stall counter clears.

## Test plan
- Basic write/read (LATENCY=1, GNT_STALL=0):
  - Write 0xDEADBEEF to 0x10, be=4'b1111: gnt same cycle, rvalid next cycle with rdata=0.
  - Then read 0x10: gnt same cycle, rvalid next cycle with rdata=0xDEADBEEF.
- Byte enables: write 0x11223344 with be=4'b0101 over 0xDEADBEEF at 0x10, then read 0x10 → rdata=0xDE22BE44.
- Back-to-back (LATENCY=1): req_i held 4 cycles reading 0x0, 0x4, 0x8, 0xC preloaded with 1,2,3,4 → gnt in cycles 0-3, rvalid in cycles 1-4 with rdata 1,2,3,4 in order.
- Stalls (LATENCY=3, GNT_STALL=2): req_i rises at cycle 0 and is held → gnt in cycle 2, rvalid only in cycle 5. Second request stays held → gnt in cycle 5 (RESP), rvalid in cycle 8, gnt=0 in cycles 3-4 and 6-7.
- Aliasing (DEPTH=1024): write 0xCAFEF00D to 0x1004, then read 0x0004 → rdata=0xCAFEF00D.
- Reset mid-operation (LATENCY=3): grant a write of 0xA5A5A5A5 to 0x20, assert rst one cycle later → rvalid never pulses and rdata_o=0. After release, read 0x20 → 0xA5A5A5A5.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port req/gnt/rvalid memory responder with programmable grant
// stall and response latency; stands in for on-chip RAM behind a port mux.
module mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1,
    parameter int GNT_STALL  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int STL_W = (GNT_STALL > 0) ? $clog2(GNT_STALL + 1) : 1;

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);
    localparam logic [STL_W-1:0] STL_MAX  = STL_W'(GNT_STALL);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [STL_W-1:0]      stall_q;
    logic [LAT_W-1:0]      lat_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [IDX_W-1:0]      idx;
    logic                  accept;
    logic                  unused_addr;

    // Byte offset and bits above the array index are dropped (aliasing).
    assign idx         = addr_i[OFF_W +: IDX_W];
    assign unused_addr = ^addr_i;

    assign accept     = (state_q == IDLE) || (state_q == RESP);
    assign gnt_o      = req_i && !rst && accept && (stall_q == STL_MAX);
    assign rvalid_o   = (state_q == RESP);
    assign rdata_o    = rdata_q;
    assign grant_data = we_i ? '0 : mem[idx];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (gnt_o) begin
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (lat_q <= LAT_W'(1)) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !req_i || gnt_o) begin
            stall_q <= '0;
        end else if (stall_q != STL_MAX) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q <= '0;
        end else if (gnt_o) begin
            lat_q <= LAT_LOAD;
        end else if (state_q == WAIT && lat_q != '0) begin
            lat_q <= lat_q - 1'b1;
        end
    end

    // rdata_o only changes when a response is presented, then holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= '0;
            rdata_q <= '0;
        end else if (gnt_o) begin
            hold_q <= grant_data;
            if (LATENCY == 1) begin
                rdata_q <= grant_data;
            end
        end else if (state_q == WAIT && state_d == RESP) begin
            rdata_q <= hold_q;
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_o && we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem[idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

endmodule
